// File: rtl/packet_merge_2to1.sv
// Two-input round-robin packet merge with a single registered output slot.
// Optional per-input accepted-packet counters are enabled by defining MERGE_STATS_EN.
module packet_merge_2to1 #(
   parameter int DWIDTH = 8,
   parameter int PWIDTH = 47,
   parameter int CNTW   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [PWIDTH-1:0] in0_packet,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [PWIDTH-1:0] in1_packet,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PWIDTH-1:0] out_packet,
   output logic              out_src
`ifdef MERGE_STATS_EN
   ,
   output logic [CNTW-1:0]   cnt0,
   output logic [CNTW-1:0]   cnt1
`endif
);

   // Handshake rule for all three ports: a packet moves on a rising edge
   // exactly when valid and ready are both high; valid never waits for ready.

   if (DWIDTH > PWIDTH) begin : g_width_check
      $error("packet_merge_2to1: DWIDTH must not exceed PWIDTH");
   end

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t state;
   state_t state_next;
   logic   prio;
   logic   load;
   logic   grant_any;
   logic   grant_idx;
   logic   take0;
   logic   take1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      grant_any  = 1'b0;
      grant_idx  = 1'b0;
      in0_ready  = 1'b0;
      in1_ready  = 1'b0;
      take0      = 1'b0;
      take1      = 1'b0;

      // The slot can accept when empty or when its packet leaves this cycle.
      load      = (state == S_EMPTY) || out_ready;
      grant_any = in0_valid || in1_valid;
      grant_idx = (in0_valid && in1_valid) ? prio : in1_valid;
      in0_ready = !rst && load && grant_any && !grant_idx;
      in1_ready = !rst && load && grant_any && grant_idx;
      take0     = in0_valid && in0_ready;
      take1     = in1_valid && in1_ready;

      if (take0 || take1) begin
         state_next = S_FULL;
      end else if ((state == S_FULL) && out_ready) begin
         state_next = S_EMPTY;
      end
   end

   assign out_valid = (state == S_FULL);

   // Payload and source hold their last values when the slot drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_packet <= '0;
         out_src    <= 1'b0;
         prio       <= 1'b0;
      end else if (take0) begin
         out_packet <= in0_packet;
         out_src    <= 1'b0;
         prio       <= 1'b1;
      end else if (take1) begin
         out_packet <= in1_packet;
         out_src    <= 1'b1;
         prio       <= 1'b0;
      end
   end

`ifdef MERGE_STATS_EN
   // Saturating counters: they stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (take0 && (cnt0 != {CNTW{1'b1}})) begin
            cnt0 <= cnt0 + 1'b1;
         end
         if (take1 && (cnt1 != {CNTW{1'b1}})) begin
            cnt1 <= cnt1 + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_packet_merge_2to1.sv
// Directed and randomized bench for packet_merge_2to1 against a cycle-level reference model.
// Define MERGE_STATS_EN to also exercise the saturating counters (built with CNTW = 4).
module tb_packet_merge_2to1;

   localparam int PW = 47;
`ifdef MERGE_STATS_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in0_valid = 1'b0;
   logic          in1_valid = 1'b0;
   logic [PW-1:0] in0_packet = '0;
   logic [PW-1:0] in1_packet = '0;
   logic          out_ready = 1'b0;
   logic          in0_ready;
   logic          in1_ready;
   logic          out_valid;
   logic [PW-1:0] out_packet;
   logic          out_src;
`ifdef MERGE_STATS_EN
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;
`endif

   always #5 clk = ~clk;

   packet_merge_2to1 #(.DWIDTH(8), .PWIDTH(PW), .CNTW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in0_valid  (in0_valid),
      .in0_ready  (in0_ready),
      .in0_packet (in0_packet),
      .in1_valid  (in1_valid),
      .in1_ready  (in1_ready),
      .in1_packet (in1_packet),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_packet (out_packet),
      .out_src    (out_src)
`ifdef MERGE_STATS_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   // ---------------- reference model / scoreboard ----------------
   int            n_checks = 0;
   int            n_fail = 0;
   bit            m_full;
   bit            m_src;
   bit            m_prio;
   logic [PW-1:0] m_pkt;
   int            m_cnt0;
   int            m_cnt1;
   bit            t0;
   bit            t1;
   logic [PW-1:0] exp_q0[$];
   logic [PW-1:0] exp_q1[$];
   logic [PW-1:0] out_seq[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 0;
      m_src  = 0;
      m_prio = 0;
      m_pkt  = '0;
      m_cnt0 = 0;
      m_cnt1 = 0;
   endtask

   // One clock: check readies and deliveries at the negedge, model the edge, check the slot after it.
   task automatic step();
      bit            load;
      bit            gv;
      bit            g;
      logic [PW-1:0] e;
      int            cmax;
      cmax = (1 << CW) - 1;
      @(negedge clk);
      gv   = in0_valid || in1_valid;
      g    = (in0_valid && in1_valid) ? m_prio : in1_valid;
      load = !m_full || out_ready;
      chk("in0_ready", in0_ready, !rst && load && gv && !g);
      chk("in1_ready", in1_ready, !rst && load && gv && g);
      if (out_valid && out_ready && !rst) begin
         e = '1;
         if (out_src) begin
            chk("deliver_q1_nonempty", q_nonempty(1), 1);
            if (exp_q1.size() > 0) e = exp_q1.pop_front();
         end else begin
            chk("deliver_q0_nonempty", q_nonempty(0), 1);
            if (exp_q0.size() > 0) e = exp_q0.pop_front();
         end
         chk("deliver_pkt", out_packet, e);
         out_seq.push_back(out_packet);
      end
      t0 = in0_valid && !rst && load && gv && !g;
      t1 = in1_valid && !rst && load && gv && g;
      if (t0) exp_q0.push_back(in0_packet);
      if (t1) exp_q1.push_back(in1_packet);
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else if (t0) begin
         m_full = 1; m_pkt = in0_packet; m_src = 0; m_prio = 1;
         if (m_cnt0 < cmax) m_cnt0++;
      end else if (t1) begin
         m_full = 1; m_pkt = in1_packet; m_src = 1; m_prio = 0;
         if (m_cnt1 < cmax) m_cnt1++;
      end else if (m_full && out_ready) begin
         m_full = 0;
      end
      chk("out_valid", out_valid, m_full);
      chk("out_packet", out_packet, m_pkt);
      chk("out_src", out_src, m_src);
`ifdef MERGE_STATS_EN
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
`endif
   endtask

   function automatic bit q_nonempty(input bit src);
      return src ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_packet", out_packet, 0);
      model_reset();
      exp_q0.delete();
      exp_q1.delete();
      step();
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      in0_valid = 0;
      in1_valid = 0;
      out_ready = 1;
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [PW-1:0] rand_pkt();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[PW-1:0];
   endfunction

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin : main
      logic [PW-1:0] f0[3];
      logic [PW-1:0] f1[3];
      logic [PW-1:0] fexp[6];
      int            idx0;
      int            idx1;
      int            sent;

      f0   = '{47'd1, 47'd2, 47'd3};
      f1   = '{47'd101, 47'd102, 47'd103};
      fexp = '{47'd1, 47'd101, 47'd2, 47'd102, 47'd3, 47'd103};

      // Reset held with both inputs valid, then first packet one cycle after release.
      in0_valid  = 1; in0_packet = 47'h11;
      in1_valid  = 1; in1_packet = 47'h22;
      #1;
      model_reset();
      chk("rst_hold_valid", out_valid, 0);
      chk("rst_hold_pkt", out_packet, 0);
      chk("rst_hold_r0", in0_ready, 0);
      chk("rst_hold_r1", in1_ready, 0);
      step();
      step();
      rst = 0;
      in1_valid  = 0;
      in0_packet = 47'h0_0000_00A5;
      step();
      chk("first_pkt", out_packet, 47'h0_0000_00A5);
      chk("first_src", out_src, 0);
      idle(2);

      // Fairness: alternating grants starting with input 0, no bubbles.
      do_reset();
      out_seq.delete();
      idx0 = 0;
      idx1 = 0;
      out_ready = 1;
      for (int c = 0; c < 7; c++) begin
         in0_valid  = (idx0 < 3);
         in0_packet = (idx0 < 3) ? f0[idx0] : '0;
         in1_valid  = (idx1 < 3);
         in1_packet = (idx1 < 3) ? f1[idx1] : '0;
         step();
         if (t0) idx0++;
         if (t1) idx1++;
      end
      chk("fair_len", out_seq.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < out_seq.size()) chk("fair_seq", out_seq[i], fexp[i]);
      end
      idle(1);

      // Backpressure: packet 7 held for 5 cycles, then released with 8 loading on the same edge.
      out_ready = 0;
      in0_valid = 1; in0_packet = 47'd7;
      in1_valid = 0;
      step();
      in0_packet = 47'd8;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold", out_packet, 47'd7);
      end
      out_ready = 1;
      step();
      chk("bp_next", out_packet, 47'd8);
      idle(2);

      // Single requester on input 1 with out_ready toggling.
      out_seq.delete();
      sent = 0;
      for (int c = 0; c < 80 && (sent < 10 || out_valid); c++) begin
         in0_valid  = 0;
         in1_valid  = (sent < 10);
         in1_packet = 47'd200 + PW'(sent);
         out_ready  = (c % 2 == 0);
         step();
         if (t1) sent++;
      end
      chk("single_len", out_seq.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < out_seq.size()) chk("single_seq", out_seq[i], 47'd200 + PW'(i));
      end
      idle(1);
      in0_valid = 1; in0_packet = 47'h55;
      in1_valid = 1; in1_packet = 47'h66;
      #1;
      chk("prio_after_single", {in0_ready, in1_ready}, 2'b10);
      step();
      idle(2);

      // Mid-stream reset while holding 0x33: it must never reach the output.
      out_ready = 0;
      in0_valid = 1; in0_packet = 47'h33;
      step();
      chk("pre_rst_pkt", out_packet, 47'h33);
      in0_packet = 47'h44;
      #2;
      rst = 1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_r0", in0_ready, 0);
      model_reset();
      exp_q0.delete();
      exp_q1.delete();
      out_ready = 1;
      step();
      step();
      rst = 0;
      in0_valid = 0;
      step();
      step();

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         in0_valid  = $urandom_range(0, 1);
         in1_valid  = $urandom_range(0, 1);
         in0_packet = rand_pkt();
         in1_packet = rand_pkt();
         out_ready  = ($urandom_range(0, 3) != 0);
         step();
      end
      idle(3);
      chk("drain_q0_empty", exp_q0.size(), 0);
      chk("drain_q1_empty", exp_q1.size(), 0);

`ifdef MERGE_STATS_EN
      // 20 packets from input 0 and 3 from input 1 with 4-bit counters.
      do_reset();
      idx0 = 0;
      idx1 = 0;
      out_ready = 1;
      for (int c = 0; c < 60 && (idx0 < 20 || idx1 < 3); c++) begin
         in0_valid  = (idx0 < 20);
         in0_packet = rand_pkt();
         in1_valid  = (idx1 < 3);
         in1_packet = rand_pkt();
         step();
         if (t0) idx0++;
         if (t1) idx1++;
      end
      idle(2);
      chk("stats_cnt0_sat", cnt0, 15);
      chk("stats_cnt1", cnt1, 3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
